mult_pipe: RTL and testbench
============================

# mult_pipe

Parametrised, fully pipelined integer multiplier for the execute stage, replacing the fixed 4-stage, 64-bit-only multiplier. It implements all four RISC-V M-extension multiply variants (MUL, MULH, MULHSU, MULHU) for any `XLEN` and stage count. It carries a tag (ROB/PRF index) alongside each operation. It adds valid/ready backpressure, a pipeline flush for branch-mispredict recovery, and an occupancy count for issue logic.

## Interface
- `XLEN`, 32: operand and result width.
- `STAGES`, 4: pipeline depth.
  - Must divide `2*XLEN`.
  - Each stage consumes `BPS = 2*XLEN/STAGES` multiplier bits.
- `TAG_W`, 6: tag width.
- `clock`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: asynchronous, active-low reset (asserted at 0).
- `flush`, in, 1: synchronous squash of all in-flight operations.
- `in_valid`, in, 1: operation offered.
- `in_ready`, out, 1: stage 0 can accept this cycle.
- `in_func`, in, 2: operation select.
  - 00 MUL
  - 01 MULH
  - 10 MULHSU
  - 11 MULHU
- `in_a`, in, XLEN: multiplicand (rs1).
- `in_b`, in, XLEN: multiplier (rs2).
- `in_tag`, in, TAG_W: destination tag.
- `out_valid`, out, 1: result available at final stage.
- `out_ready`, in, 1: consumer accepts result.
- `out_result`, out, XLEN: selected product half.
- `out_tag`, out, TAG_W: tag of the result.
- `occupancy`, out, $clog2(STAGES+1): count of valid stages.

## Operation
- Operand extension to `2*XLEN`:
  - MUL and MULHU: both operands zero-extended (low half of MUL is identical either way).
  - MULH: both operands sign-extended.
  - MULHSU: `in_a` sign-extended, `in_b` zero-extended.
- Each stage register holds `{valid, func, tag, mcand, mplier, acc}`.
- Stage k operation:
  - Adds `mplier[BPS-1:0] * mcand` into `acc` (mod `2^(2*XLEN)`).
  - Shifts `mplier` right by `BPS`.
  - Shifts `mcand` left by `BPS`.
- After `STAGES` stages, `acc` equals the full `2*XLEN` two's-complement product.
- Result select:
  - MUL: `out_result = acc[XLEN-1:0]`.
  - All other funcs: `out_result = acc[2*XLEN-1:XLEN]`.
  - Select is a combinational mux of the last-stage register only; no adder after the last register.
- Flow control, with `adv[k]` meaning stage k's contents move on this cycle:
  - `adv[STAGES-1] = v[STAGES-1] & out_ready`.
  - `adv[k] = v[k] & (!v[k+1] | adv[k+1])`.
  - Stage k loads when `!v[k] | adv[k]`; a stage not loading holds all fields unchanged.
  - Bubbles collapse: a stalled stage with an empty successor still advances.
  - `in_ready = !v[0] | adv[0]`, combinational from `out_ready`.
  - Transfer occurs when `in_valid & in_ready`.
- `out_valid = v[STAGES-1]`; `out_tag` and `out_result` are stable while `out_valid & !out_ready`.
- `flush`:
  - Next edge clears every `v[k]`, `occupancy` becomes 0.
  - An input offered in the flush cycle is dropped.
  - `in_ready` is unaffected by `flush`.
  - Data fields need not clear.
- `occupancy` is the registered popcount of `v`.
  - It updates every edge: +1 on accept, −1 on output transfer, both on the same edge give net 0.

## Timing
- Reset (asynchronous on `reset`=0, released synchronously by the environment):
  - All `v`=0; `out_valid`=0, `occupancy`=0.
  - `out_result`=0, `out_tag`=0 (all data registers reset to 0).
  - `in_ready`=1 once in reset.
- Latency: an op accepted at edge N shows `out_valid`=1 after edge N+STAGES−1 when unstalled (STAGES cycles of registering including stage 0's capture).
- Throughput: one op per cycle with `out_ready` held high.
- Full pipe with `out_ready`=0: `in_ready`=0, `occupancy`=STAGES.
  - Raising `out_ready` raises `in_ready` in the same cycle (accept and drain on one edge).
- Reset mid-operation: all in-flight ops are lost and no `out_valid` pulse follows.
- `flush` and `out_ready` in the same cycle: the final-stage result counts as consumed by the consumer; its tag is squashed by issue logic.

## Test plan
- XLEN=32, STAGES=4: MUL a=0xFFFFFFFF b=0xFFFFFFFF tag=3 -> `out_result`=0x00000001, `out_tag`=3, 4 cycles after accept.
- Same operands:
  - MULH -> 0x00000000.
  - MULHU -> 0xFFFFFFFE.
  - MULHSU -> 0xFFFFFFFF.
- MULH a=b=0x80000000 -> 0x40000000.
- Back-to-back 16 random ops with random `out_ready` stalls -> results match reference model in order with correct tags.
  - No drop or duplicate.
  - Outputs held stable during stall.
  - `occupancy` never exceeds 4.
- Fill pipe with `out_ready`=0 -> `in_ready`=0 after 4 accepts, `occupancy`=4.
  - Assert `flush` -> next cycle `out_valid`=0, `occupancy`=0, `in_ready`=1.
- Assert `reset`=0 asynchronously mid-stream (between edges) -> `out_valid`, `out_result`, `out_tag`, `occupancy` go to 0 immediately.
  - After release, first new op returns the correct result with latency 4.
- Parameter sweep XLEN=64/STAGES=8 and XLEN=16/STAGES=2 -> all four funcs match reference model on corner operands (0, 1, −1, min-negative, max-positive).

Source files
------------

// File: rtl/mult_pipe.sv
// mult_pipe: fully pipelined RISC-V M-extension multiplier (MUL, MULH, MULHSU, MULHU).
//
// Each operand is extended to 2*XLEN bits, and each stage then retires
// BPS = 2*XLEN/STAGES multiplier bits as one partial product folded into a
// running accumulator. Stage 0 does its step on the way into its register, so
// an operation accepted on edge N is in the last register after edge N+STAGES-1.
// The result mux reads only that last register; there is no adder after it.
// STAGES must divide 2*XLEN, and STAGES >= 2.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous, active-low reset
//   flush      - synchronous squash of every in-flight operation
//   in_valid   - operation offered           in_ready   - stage 0 can take it
//   in_func    - 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_a/in_b  - rs1 / rs2 operands          in_tag     - destination tag
//   out_valid  - result in final stage       out_ready  - consumer takes it
//   out_result - selected product half       out_tag    - tag of that result
//   occupancy  - number of valid stages
module mult_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_func,
  input  logic [XLEN-1:0]              in_a,
  input  logic [XLEN-1:0]              in_b,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_result,
  output logic [TAG_W-1:0]             out_tag,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int DW  = 2 * XLEN;
  localparam int BPS = DW / STAGES;
  localparam int OW  = $clog2(STAGES + 1);

  localparam logic [1:0] FN_MUL    = 2'b00;
  localparam logic [1:0] FN_MULH   = 2'b01;
  localparam logic [1:0] FN_MULHSU = 2'b10;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              a_signed;
  logic              b_signed;
  logic [DW-1:0]     ext_a;
  logic [DW-1:0]     ext_b;
  logic              in_xfer;
  logic              out_xfer;

  // MUL takes the low half, which is the same for any extension, so it
  // shares the zero-extended path with MULHU.
  assign a_signed = (in_func == FN_MULH) || (in_func == FN_MULHSU);
  assign b_signed = (in_func == FN_MULH);
  assign ext_a    = {{XLEN{a_signed & in_a[XLEN-1]}}, in_a};
  assign ext_b    = {{XLEN{b_signed & in_b[XLEN-1]}}, in_b};

  // A valid stage moves on when the consumer is ready or when any later
  // stage is empty (bubbles collapse). The mask selects the stages above k;
  // for the last stage it is empty, leaving just out_ready.
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = v_q[k] & (out_ready | ~&(v_q | ~({STAGES{1'b1}} << (k + 1))));
    end
  end

  assign load     = ~v_q | adv;
  assign in_ready = load[0];
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = adv[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Multiplier bits still unconsumed on entry to this stage.
    localparam int RW = DW - k * BPS;

    logic             s_valid;
    logic [1:0]       s_func;
    logic [TAG_W-1:0] s_tag;
    logic [DW-1:0]    s_mcand;
    logic [DW-1:0]    s_acc;
    logic [RW-1:0]    s_mplier;
    logic [DW-1:0]    acc_d;

    logic             valid_q;
    logic [1:0]       func_q;
    logic [TAG_W-1:0] tag_q;
    logic [DW-1:0]    acc_q;

    if (k == 0) begin : g_src
      assign s_valid  = in_valid;
      assign s_func   = in_func;
      assign s_tag    = in_tag;
      assign s_mcand  = ext_a;
      assign s_mplier = ext_b;
      assign s_acc    = '0;
    end else begin : g_src
      assign s_valid  = adv[k-1];
      assign s_func   = g_stage[k-1].func_q;
      assign s_tag    = g_stage[k-1].tag_q;
      assign s_mcand  = g_stage[k-1].g_carry.mcand_q;
      assign s_mplier = g_stage[k-1].g_carry.mplier_q;
      assign s_acc    = g_stage[k-1].acc_q;
    end

    // Wrap-around modulo 2^DW gives the correct two's-complement product.
    assign acc_d  = s_acc + DW'(s_mplier[BPS-1:0]) * s_mcand;
    assign v_q[k] = valid_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        func_q  <= '0;
        tag_q   <= '0;
        acc_q   <= '0;
      end else begin
        if (flush) begin
          valid_q <= 1'b0;
        end else if (load[k]) begin
          valid_q <= s_valid;
        end
        if (load[k]) begin
          func_q <= s_func;
          tag_q  <= s_tag;
          acc_q  <= acc_d;
        end
      end
    end

    // The last stage has consumed every multiplier bit, so only earlier
    // stages carry the shifted operands forward.
    if (k < STAGES - 1) begin : g_carry
      logic [DW-1:0]     mcand_q;
      logic [RW-BPS-1:0] mplier_q;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          mcand_q  <= '0;
          mplier_q <= '0;
        end else if (load[k]) begin
          mcand_q  <= {s_mcand[DW-BPS-1:0], {BPS{1'b0}}};
          mplier_q <= s_mplier[RW-1:BPS];
        end
      end
    end
  end

  assign out_valid  = v_q[STAGES-1];
  assign out_tag    = g_stage[STAGES-1].tag_q;
  assign out_result = (g_stage[STAGES-1].func_q == FN_MUL) ?
                      g_stage[STAGES-1].acc_q[XLEN-1:0] :
                      g_stage[STAGES-1].acc_q[DW-1:XLEN];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OW'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OW'(1);
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: a 32/4 instance with a scoreboard and monitor, plus
// 64/8 and 16/2 instances driven with corner operands for every func.
module tb_mult_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, flush, in_valid, out_ready;
  logic [1:0]  in_func;
  logic [31:0] in_a, in_b;
  logic [5:0]  in_tag;
  logic        in_ready, out_valid;
  logic [31:0] out_result;
  logic [5:0]  out_tag;
  logic [2:0]  occupancy;

  logic        s_valid, s_flush, s_ordy;
  logic [1:0]  s_func;
  logic [5:0]  s_tag;
  logic [63:0] s64_a, s64_b, s64_res;
  logic [15:0] s16_a, s16_b, s16_res;
  logic        s64_ir, s64_ov, s16_ir, s16_ov;
  logic [5:0]  s64_tag, s16_tag;
  logic [3:0]  s64_occ;
  logic [1:0]  s16_occ;

  mult_pipe #(.XLEN(32), .STAGES(4), .TAG_W(6)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .occupancy(occupancy)
  );

  mult_pipe #(.XLEN(64), .STAGES(8), .TAG_W(6)) u64 (
    .clock(clock), .reset(reset), .flush(s_flush),
    .in_valid(s_valid), .in_ready(s64_ir), .in_func(s_func),
    .in_a(s64_a), .in_b(s64_b), .in_tag(s_tag),
    .out_valid(s64_ov), .out_ready(s_ordy), .out_result(s64_res),
    .out_tag(s64_tag), .occupancy(s64_occ)
  );

  mult_pipe #(.XLEN(16), .STAGES(2), .TAG_W(6)) u16 (
    .clock(clock), .reset(reset), .flush(s_flush),
    .in_valid(s_valid), .in_ready(s16_ir), .in_func(s_func),
    .in_a(s16_a), .in_b(s16_b), .in_tag(s_tag),
    .out_valid(s16_ov), .out_ready(s_ordy), .out_result(s16_res),
    .out_tag(s16_tag), .occupancy(s16_occ)
  );

  typedef struct packed {
    logic [63:0] res;
    logic [5:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t sb64[$];
  exp_t sb16[$];
  exp_t em, e64, e16;

  int          checks = 0;
  int          errors = 0;
  int          model_occ = 0;
  bit          stall_prev = 0;
  bit          rand_on = 0;
  logic [31:0] held_res;
  logic [5:0]  held_tag;
  logic [63:0] c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/none expected event", name);
  endtask

  // Value-level reference: interpret each operand as a signed or unsigned
  // integer, multiply exactly, then take the requested half.
  function automatic logic [63:0] ref_mul(input int xw, input logic [1:0] fn,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [131:0] va, vb, mask, p;
    mask = (132'd1 << xw) - 132'd1;
    va = {68'd0, a} & mask;
    vb = {68'd0, b} & mask;
    if ((fn == 2'b01 || fn == 2'b10) && a[xw-1]) va = va - (132'd1 << xw);
    if (fn == 2'b01 && b[xw-1]) vb = vb - (132'd1 << xw);
    p = va * vb;
    if (fn == 2'b00) return 64'(p & mask);
    return 64'((p >> xw) & mask);
  endfunction

  function automatic logic [63:0] corner(input int w, input int idx);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    case (idx)
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return m;
      3:       return 64'd1 << (w - 1);
      default: return m >> 1;
    endcase
  endfunction

  // Main monitor: occupancy and in_ready against a count of in-flight ops,
  // output hold during stalls, and in-order scoreboard pops.
  always @(negedge clock) begin
    if (!reset) begin
      sb.delete();
      model_occ  = 0;
      stall_prev = 0;
    end else begin
      chk("occupancy", 64'(occupancy), 64'(model_occ));
      chk("in_ready", 64'(in_ready), 64'(!(model_occ == 4 && !out_ready)));
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_result", 64'(out_result), 64'(held_res));
        chk("stall_tag", 64'(out_tag), 64'(held_tag));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail("unexpected_output");
        end else begin
          em = sb.pop_front();
          chk("result", 64'(out_result), em.res);
          chk("tag", 64'(out_tag), 64'(em.tag));
        end
      end
      stall_prev = out_valid && !out_ready && !flush;
      held_res   = out_result;
      held_tag   = out_tag;
      if (flush) begin
        model_occ = 0;
        sb.delete();
      end else begin
        model_occ = model_occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      if (s64_ov) begin
        if (sb64.size() == 0) begin
          fail("s64_unexpected_output");
        end else begin
          e64 = sb64.pop_front();
          chk("s64_result", s64_res, e64.res);
          chk("s64_tag", 64'(s64_tag), 64'(e64.tag));
        end
      end
      if (s16_ov) begin
        if (sb16.size() == 0) begin
          fail("s16_unexpected_output");
        end else begin
          e16 = sb16.pop_front();
          chk("s16_result", 64'(s16_res), e16.res);
          chk("s16_tag", 64'(s16_tag), 64'(e16.tag));
        end
      end
    end
  end

  task automatic send(input logic [1:0] fn, input logic [31:0] x, input logic [31:0] y,
                      input logic [5:0] t);
    bit   done = 0;
    exp_t e;
    in_valid = 1'b1;
    in_func  = fn;
    in_a     = x;
    in_b     = y;
    in_tag   = t;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clock);
      if (in_ready && !flush) begin
        e.res = ref_mul(32, fn, {32'd0, x}, {32'd0, y});
        e.tag = t;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!done) fail("accept_timeout");
  endtask

  task automatic directed(input string name, input logic [1:0] fn, input logic [31:0] x,
                          input logic [31:0] y, input logic [5:0] t, input logic [31:0] want);
    int n;
    send(fn, x, y, t);
    for (n = 1; n <= 12; n++) begin
      @(negedge clock);
      if (out_valid) break;
    end
    chk({name, "_latency"}, 64'(n), 64'd4);
    chk({name, "_result"}, 64'(out_result), 64'(want));
    chk({name, "_tag"}, 64'(out_tag), 64'(t));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_func = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
    s_valid = 1'b0; s_flush = 1'b0; s_ordy = 1'b1; s_func = 2'b00; s_tag = '0;
    s64_a = '0; s64_b = '0; s16_a = '0; s16_b = '0;

    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_s64_valid", 64'(s64_ov), 64'd0);
    chk("rst_s16_valid", 64'(s16_ov), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    directed("mul_ff",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3, 32'h0000_0001);
    directed("mulh_ff",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4, 32'h0000_0000);
    directed("mulhu_ff",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5, 32'hFFFF_FFFE);
    directed("mulhsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd6, 32'hFFFF_FFFF);
    directed("mulh_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 6'd7, 32'h4000_0000);

    // Random ops with random consumer stalls.
    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          @(posedge clock);
          #1;
          if (rand_on) out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join_none
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      c  = corner(32, $urandom_range(0, 4));
      ra = ($urandom_range(0, 3) == 0) ? c[31:0] : $urandom;
      rb = $urandom;
      send(2'($urandom_range(0, 3)), ra, rb, 6'(8 + i));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clock);
        #1;
      end
    end
    rand_on   = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clock);
    #1;
    chk("drain_random", 64'(sb.size()), 64'd0);

    // Fill with the consumer stalled, then flush.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'(i), $urandom, $urandom, 6'(30 + i));
    @(negedge clock);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_occupancy", 64'(occupancy), 64'd4);
    chk("fill_out_valid", 64'(out_valid), 64'd1);
    @(posedge clock);
    #1;
    flush = 1'b1; in_valid = 1'b1; in_func = 2'b00; in_a = 32'd9; in_b = 32'd9; in_tag = 6'd40;
    @(negedge clock);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("post_flush_valid", 64'(out_valid), 64'd0);
    chk("post_flush_occupancy", 64'(occupancy), 64'd0);
    chk("post_flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;

    // Asynchronous reset with results in flight.
    send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd33);
    for (int i = 0; i < 3; i++) send(2'(i), $urandom, $urandom, 6'(34 + i));
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_result", 64'(out_result), 64'd0);
    chk("async_rst_tag", 64'(out_tag), 64'd0);
    chk("async_rst_occupancy", 64'(occupancy), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    directed("post_rst", 2'b00, 32'd7, 32'd6, 6'd5, 32'd42);

    // Corner sweep on the 64/8 and 16/2 instances.
    s_valid = 1'b1;
    for (int fn = 0; fn < 4; fn++) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          exp_t e;
          s_func = 2'(fn);
          s_tag  = 6'(fn * 25 + i * 5 + j);
          s64_a  = corner(64, i);
          s64_b  = corner(64, j);
          c      = corner(16, i);
          s16_a  = c[15:0];
          c      = corner(16, j);
          s16_b  = c[15:0];
          @(negedge clock);
          if (s64_ir) begin
            e.res = ref_mul(64, s_func, s64_a, s64_b);
            e.tag = s_tag;
            sb64.push_back(e);
          end else begin
            fail("s64_not_ready");
          end
          if (s16_ir) begin
            e.res = ref_mul(16, s_func, {48'd0, s16_a}, {48'd0, s16_b});
            e.tag = s_tag;
            sb16.push_back(e);
          end else begin
            fail("s16_not_ready");
          end
          @(posedge clock);
          #1;
        end
      end
    end
    s_valid = 1'b0;
    for (int n = 0; n < 40 && (sb64.size() != 0 || sb16.size() != 0); n++) @(posedge clock);
    #1;
    @(negedge clock);
    chk("drain_s64", 64'(sb64.size()), 64'd0);
    chk("drain_s16", 64'(sb16.size()), 64'd0);
    chk("drain_main", 64'(sb.size()), 64'd0);
    chk("s64_occ_idle", 64'(s64_occ), 64'd0);
    chk("s16_occ_idle", 64'(s16_occ), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
